// File: rtl/vga_sram_arbiter.sv
// rtl/vga_sram_arbiter.sv - display-priority arbiter sharing one VGA SRAM Wishbone port with the CPU
// Optional grant watchdog enabled by defining VGA_ARB_TIMEOUT_EN.
module vga_sram_arbiter #(
    parameter int MAX_DISP_BURST = 8,
    parameter int TIMEOUT        = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [16:0] cpu_adr_i,
    input  logic [1:0]  cpu_sel_i,
    input  logic        cpu_we_i,
    input  logic [15:0] cpu_dat_i,
    output logic [15:0] cpu_dat_o,
    input  logic        cpu_stb_i,
    output logic        cpu_ack_o,
    input  logic [16:0] disp_adr_i,
    output logic [15:0] disp_dat_o,
    input  logic        disp_stb_i,
    output logic        disp_ack_o,
    output logic [16:0] sram_adr_o,
    output logic [1:0]  sram_sel_o,
    output logic        sram_we_o,
    output logic [15:0] sram_dat_o,
    input  logic [15:0] sram_dat_i,
    output logic        sram_stb_o,
    input  logic        sram_ack_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    localparam int CW = $clog2(MAX_DISP_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DISP_BURST);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DISP = 2'd1,
        S_CPU  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   disp_cnt_q, disp_cnt_d;
    logic            tmo_fire;

`ifdef VGA_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_q;

    // Counter restarts in IDLE so every new grant gets a full window.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q != S_IDLE) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    assign tmo_fire  = (state_q != S_IDLE) && (tmo_cnt_q == TW'(TIMEOUT)) && !sram_ack_i;
    assign timeout_o = timeout_q && !wb_rst_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_fire  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            disp_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            disp_cnt_q <= disp_cnt_d;
        end
    end

    // Display wins unless the CPU has already waited out a full burst.
    always_comb begin
        state_d    = state_q;
        disp_cnt_d = disp_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (disp_stb_i && !(cpu_stb_i && disp_cnt_q == CNT_MAX)) begin
                    state_d = S_DISP;
                    if (!cpu_stb_i) begin
                        disp_cnt_d = '0;
                    end else if (disp_cnt_q != CNT_MAX) begin
                        disp_cnt_d = disp_cnt_q + CW'(1);
                    end
                end else if (cpu_stb_i) begin
                    state_d    = S_CPU;
                    disp_cnt_d = '0;
                end else begin
                    disp_cnt_d = '0;
                end
            end
            S_DISP: begin
                if (!disp_stb_i || sram_ack_i || tmo_fire) begin
                    state_d = S_IDLE;
                end
            end
            S_CPU: begin
                if (!cpu_stb_i || sram_ack_i || tmo_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset gates every output so nothing leaks during a mid-transaction reset.
    always_comb begin
        sram_adr_o = '0;
        sram_sel_o = '0;
        sram_we_o  = 1'b0;
        sram_dat_o = '0;
        sram_stb_o = 1'b0;
        cpu_dat_o  = '0;
        cpu_ack_o  = 1'b0;
        disp_dat_o = '0;
        disp_ack_o = 1'b0;
        grant_o    = 2'b00;
        if (!wb_rst_i) begin
            case (state_q)
                S_DISP: begin
                    grant_o    = 2'b01;
                    sram_adr_o = disp_adr_i;
                    sram_sel_o = 2'b11;
                    sram_stb_o = disp_stb_i && !tmo_fire;
                    disp_ack_o = disp_stb_i && (sram_ack_i || tmo_fire);
                    disp_dat_o = tmo_fire ? 16'hFFFF : sram_dat_i;
                end
                S_CPU: begin
                    grant_o    = 2'b10;
                    sram_adr_o = cpu_adr_i;
                    sram_sel_o = cpu_sel_i;
                    sram_we_o  = cpu_we_i;
                    sram_dat_o = cpu_dat_i;
                    sram_stb_o = cpu_stb_i && !tmo_fire;
                    cpu_ack_o  = cpu_stb_i && (sram_ack_i || tmo_fire);
                    cpu_dat_o  = tmo_fire ? 16'hFFFF : sram_dat_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// tb/tb_vga_sram_arbiter.sv - directed self-checking bench for vga_sram_arbiter
module tb_vga_sram_arbiter;

`ifdef VGA_ARB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] cpu_adr;
    logic [1:0]  cpu_sel;
    logic        cpu_we;
    logic [15:0] cpu_dat_w;
    logic [15:0] cpu_dat_r;
    logic        cpu_stb;
    logic        cpu_ack;
    logic [16:0] disp_adr;
    logic [15:0] disp_dat;
    logic        disp_stb;
    logic        disp_ack;
    logic [16:0] sram_adr;
    logic [1:0]  sram_sel;
    logic        sram_we;
    logic [15:0] sram_dat_w;
    logic [15:0] sram_dat_r;
    logic        sram_stb;
    logic        sram_ack;
    logic [1:0]  grant;
    logic        timeout;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    vga_sram_arbiter #(.MAX_DISP_BURST(8), .TIMEOUT(TMO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .cpu_adr_i  (cpu_adr),
        .cpu_sel_i  (cpu_sel),
        .cpu_we_i   (cpu_we),
        .cpu_dat_i  (cpu_dat_w),
        .cpu_dat_o  (cpu_dat_r),
        .cpu_stb_i  (cpu_stb),
        .cpu_ack_o  (cpu_ack),
        .disp_adr_i (disp_adr),
        .disp_dat_o (disp_dat),
        .disp_stb_i (disp_stb),
        .disp_ack_o (disp_ack),
        .sram_adr_o (sram_adr),
        .sram_sel_o (sram_sel),
        .sram_we_o  (sram_we),
        .sram_dat_o (sram_dat_w),
        .sram_dat_i (sram_dat_r),
        .sram_stb_o (sram_stb),
        .sram_ack_i (sram_ack),
        .grant_o    (grant),
        .timeout_o  (timeout)
    );

    task automatic do_reset();
        rst      = 1'b1;
        cpu_stb  = 1'b0;
        disp_stb = 1'b0;
        sram_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        disp_stb   = 1'b1;
        cpu_stb    = 1'b1;
        disp_adr   = 17'h1ABCD;
        sram_ack   = 1'b1;
        sram_dat_r = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({grant, sram_stb, cpu_ack, disp_ack, sram_we} !== 6'b0) begin
                fails++;
                $display("FAIL reset_ctrl cycle %0d: got %b expected 000000", c, {grant, sram_stb, cpu_ack, disp_ack, sram_we});
            end
            checks++;
            if ({sram_adr, disp_dat, cpu_dat_r} !== 49'h0) begin
                fails++;
                $display("FAIL reset_data cycle %0d: got %h expected 0", c, {sram_adr, disp_dat, cpu_dat_r});
            end
        end
        rst      = 1'b0;
        sram_ack = 1'b0;
        #1;
        checks++;
        if (grant !== 2'b00) begin
            fails++;
            $display("FAIL reset_release_idle: got %b expected 00", grant);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({grant, sram_stb, sram_sel, sram_we} !== 6'b01_1_11_0) begin
            fails++;
            $display("FAIL first_grant_disp: got %b expected 011110", {grant, sram_stb, sram_sel, sram_we});
        end
        checks++;
        if (sram_adr !== 17'h1ABCD) begin
            fails++;
            $display("FAIL first_grant_adr: got %h expected 1abcd", sram_adr);
        end
    endtask

    task automatic test_cpu_write();
        do_reset();
        cpu_adr   = 17'h00123;
        cpu_dat_w = 16'hBEEF;
        cpu_sel   = 2'b01;
        cpu_we    = 1'b1;
        cpu_stb   = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({grant, sram_stb, sram_we, sram_sel, cpu_ack} !== 7'b10_1_1_01_0) begin
            fails++;
            $display("FAIL cpu_write_ctrl: got %b expected 1011010", {grant, sram_stb, sram_we, sram_sel, cpu_ack});
        end
        checks++;
        if ({sram_adr, sram_dat_w} !== {17'h00123, 16'hBEEF}) begin
            fails++;
            $display("FAIL cpu_write_bus: got %h/%h expected 00123/beef", sram_adr, sram_dat_w);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cpu_ack !== 1'b0) begin
            fails++;
            $display("FAIL cpu_write_early_ack: got %b expected 0", cpu_ack);
        end
        @(posedge clk);
        #1;
        sram_ack = 1'b1;
        #1;
        checks++;
        if ({cpu_ack, disp_ack, grant} !== 4'b1_0_10) begin
            fails++;
            $display("FAIL cpu_write_ack: got %b expected 1010", {cpu_ack, disp_ack, grant});
        end
        @(posedge clk);
        #1;
        cpu_stb  = 1'b0;
        sram_ack = 1'b0;
        #1;
        checks++;
        if ({grant, cpu_ack, sram_stb} !== 4'b0000) begin
            fails++;
            $display("FAIL cpu_write_bubble: got %b expected 0000", {grant, cpu_ack, sram_stb});
        end
        cpu_we = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [18];
        int         n = 0;
        do_reset();
        cpu_adr  = 17'h00042;
        cpu_sel  = 2'b11;
        cpu_we   = 1'b0;
        disp_adr = 17'h00100;
        disp_stb = 1'b1;
        cpu_stb  = 1'b1;
        for (int c = 0; c < 100 && n < 18; c++) begin
            @(posedge clk);
            #1;
            if (grant != 2'b00) begin
                seq[n]   = grant;
                n++;
                sram_ack = 1'b1;
            end else begin
                sram_ack = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        disp_stb = 1'b0;
        cpu_stb  = 1'b0;
        sram_ack = 1'b0;
        checks++;
        if (n != 18) begin
            fails++;
            $display("FAIL burst_grant_count: got %0d expected 18", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (seq[i] !== ((i % 9 == 8) ? 2'b10 : 2'b01)) begin
                fails++;
                $display("FAIL burst_grant[%0d]: got %b expected %b", i, seq[i], (i % 9 == 8) ? 2'b10 : 2'b01);
            end
        end
    endtask

    task automatic test_disp_read();
        do_reset();
        disp_adr = 17'h00456;
        disp_stb = 1'b1;
        @(posedge clk);
        #1;
        sram_dat_r = 16'h5A5A;
        sram_ack   = 1'b1;
        #1;
        checks++;
        if ({disp_ack, disp_dat, cpu_ack, cpu_dat_r} !== {1'b1, 16'h5A5A, 1'b0, 16'h0000}) begin
            fails++;
            $display("FAIL disp_read: got %b/%h/%b/%h expected 1/5a5a/0/0000", disp_ack, disp_dat, cpu_ack, cpu_dat_r);
        end
        checks++;
        if (sram_adr !== 17'h00456) begin
            fails++;
            $display("FAIL disp_read_adr: got %h expected 00456", sram_adr);
        end
        @(posedge clk);
        #1;
        disp_stb = 1'b0;
        sram_ack = 1'b0;
        #1;
        checks++;
        if ({grant, disp_ack, disp_dat} !== 19'h0) begin
            fails++;
            $display("FAIL disp_read_idle: got %h expected 0", {grant, disp_ack, disp_dat});
        end
    endtask

    task automatic test_abort();
        do_reset();
        cpu_adr = 17'h0AAAA;
        cpu_we  = 1'b0;
        cpu_stb = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({grant, sram_stb} !== 3'b10_1) begin
            fails++;
            $display("FAIL abort_grant: got %b expected 101", {grant, sram_stb});
        end
        cpu_stb = 1'b0;
        #1;
        checks++;
        if ({sram_stb, cpu_ack} !== 2'b00) begin
            fails++;
            $display("FAIL abort_stb_drop: got %b expected 00", {sram_stb, cpu_ack});
        end
        @(posedge clk);
        #1;
        sram_ack   = 1'b1;
        sram_dat_r = 16'hDEAD;
        #1;
        checks++;
        if ({grant, cpu_ack, disp_ack, cpu_dat_r} !== 20'h0) begin
            fails++;
            $display("FAIL abort_late_ack: got %h expected 0", {grant, cpu_ack, disp_ack, cpu_dat_r});
        end
        @(posedge clk);
        #1;
        sram_ack   = 1'b0;
        cpu_adr    = 17'h00777;
        cpu_stb    = 1'b1;
        @(posedge clk);
        #1;
        sram_dat_r = 16'h1234;
        sram_ack   = 1'b1;
        #1;
        checks++;
        if ({grant, cpu_ack, cpu_dat_r, sram_adr} !== {2'b10, 1'b1, 16'h1234, 17'h00777}) begin
            fails++;
            $display("FAIL abort_next_req: got %b/%b/%h/%h expected 10/1/1234/00777", grant, cpu_ack, cpu_dat_r, sram_adr);
        end
        @(posedge clk);
        #1;
        cpu_stb  = 1'b0;
        sram_ack = 1'b0;
        #1;
        checks++;
        if (timeout !== 1'b0) begin
            fails++;
            $display("FAIL timeout_idle: got %b expected 0", timeout);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        disp_adr = 17'h00010;
        disp_stb = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 2'b01) begin
            fails++;
            $display("FAIL mid_reset_grant: got %b expected 01", grant);
        end
        rst      = 1'b1;
        sram_ack = 1'b1;
        #1;
        checks++;
        if ({grant, sram_stb, disp_ack} !== 4'b0000) begin
            fails++;
            $display("FAIL mid_reset_drop: got %b expected 0000", {grant, sram_stb, disp_ack});
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        disp_stb = 1'b0;
        sram_ack = 1'b0;
        #1;
        checks++;
        if (grant !== 2'b00) begin
            fails++;
            $display("FAIL mid_reset_idle: got %b expected 00", grant);
        end
    endtask

`ifdef VGA_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        disp_adr = 17'h00020;
        disp_stb = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (k < 5 && {disp_ack, sram_stb} !== 2'b01) begin
                fails++;
                $display("FAIL timeout_wait cycle %0d: got %b expected 01", k, {disp_ack, sram_stb});
            end else if (k == 5 && {disp_ack, sram_stb, disp_dat} !== {1'b1, 1'b0, 16'hFFFF}) begin
                fails++;
                $display("FAIL timeout_fire: got %b/%b/%h expected 1/0/ffff", disp_ack, sram_stb, disp_dat);
            end
        end
        disp_stb = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({grant, timeout} !== 3'b00_1) begin
            fails++;
            $display("FAIL timeout_flag: got %b expected 001", {grant, timeout});
        end
        @(posedge clk);
        #1;
        checks++;
        if (timeout !== 1'b1) begin
            fails++;
            $display("FAIL timeout_sticky: got %b expected 1", timeout);
        end
    endtask
`endif

    initial begin
        rst        = 1'b1;
        cpu_adr    = '0;
        cpu_sel    = '0;
        cpu_we     = 1'b0;
        cpu_dat_w  = '0;
        cpu_stb    = 1'b0;
        disp_adr   = '0;
        disp_stb   = 1'b0;
        sram_dat_r = '0;
        sram_ack   = 1'b0;
        test_reset();
        test_cpu_write();
        test_back_to_back();
        test_disp_read();
        test_abort();
        test_reset_mid();
`ifdef VGA_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
